// File: rtl/decode_stage_pkg.sv
// Global definitions for the decode stage: instruction field positions,
// opcode constants, opcode class lists, widths and the decode FSM state type.
package decode_stage_pkg;

    localparam int PC_W      = 16;
    localparam int IR_W      = 32;
    localparam int DATA_W    = 16;
    localparam int REG_N     = 16;
    localparam int REG_IDX_W = 4;
    localparam int OPC_W     = 8;

    // Instruction word field positions
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 20;
    localparam int SRC1_MSB = 19;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_MSB = 11;
    localparam int SRC2_LSB = 8;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    // Opcodes
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_LDI = 8'h04;
    localparam logic [7:0] OP_BRZ = 8'h10;
    localparam logic [7:0] OP_BRN = 8'h11;
    localparam logic [7:0] OP_JMP = 8'h12;
    localparam logic [7:0] OP_STW = 8'h20;
    localparam logic [7:0] OP_NOP = 8'hFF;

    // Opcode class lists
    localparam int N_BRANCH = 3;
    localparam int N_WRITES = 4;
    localparam logic [7:0] BRANCH_OPS [N_BRANCH] = '{OP_BRZ, OP_BRN, OP_JMP};
    localparam logic [7:0] WRITES_REG [N_WRITES] = '{OP_ADD, OP_SUB, OP_AND, OP_LDI};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_BR_WAIT = 1'b1
    } de_state_e;

    function automatic logic is_branch(input logic [7:0] op);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_BRANCH; i++) begin
            if (op == BRANCH_OPS[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic writes_reg(input logic [7:0] op);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_WRITES; i++) begin
            if (op == WRITES_REG[i]) r = 1'b1;
        end
        return r;
    endfunction

    // ALU ops, stores and the conditional branches read src1
    function automatic logic reads_src1(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_STW) || (op == OP_BRZ) || (op == OP_BRN);
    endfunction

    // ALU ops and stores read src2
    function automatic logic reads_src2(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback/branch inputs and DE/EX latch outputs of the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic                 I_LOCK;
    logic [PC_W-1:0]      I_PC;
    logic [IR_W-1:0]      I_IR;
    logic                 I_FetchStall;
    logic                 I_WBEnable;
    logic [REG_IDX_W-1:0] I_WBRegIdx;
    logic [DATA_W-1:0]    I_WBData;
    logic                 I_BranchResolved;

    logic                 O_LOCK;
    logic [PC_W-1:0]      O_PC;
    logic [OPC_W-1:0]     O_Opcode;
    logic [REG_IDX_W-1:0] O_DestIdx;
    logic [DATA_W-1:0]    O_Src1Val;
    logic [DATA_W-1:0]    O_Src2Val;
    logic [DATA_W-1:0]    O_Imm;
    logic                 O_DepStallSignal;
    logic                 O_BranchStallSignal;

    modport master (
        output I_LOCK, I_PC, I_IR, I_FetchStall, I_WBEnable, I_WBRegIdx, I_WBData,
               I_BranchResolved,
        input  O_LOCK, O_PC, O_Opcode, O_DestIdx, O_Src1Val, O_Src2Val, O_Imm,
               O_DepStallSignal, O_BranchStallSignal
    );

    modport slave (
        input  I_LOCK, I_PC, I_IR, I_FetchStall, I_WBEnable, I_WBRegIdx, I_WBData,
               I_BranchResolved,
        output O_LOCK, O_PC, O_Opcode, O_DestIdx, O_Src1Val, O_Src2Val, O_Imm,
               O_DepStallSignal, O_BranchStallSignal
    );
endinterface

// File: rtl/decode_stage_reg_scoreboard.sv
// Register busy-bit scoreboard: set on issue, clear on writeback, and a
// source-hazard query that already sees this cycle's clear.
module reg_scoreboard
    import decode_stage_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 set_en_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 clr_en_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    input  logic                 rd1_en_i,
    input  logic [REG_IDX_W-1:0] rd1_idx_i,
    input  logic                 rd2_en_i,
    input  logic [REG_IDX_W-1:0] rd2_idx_i,
    output logic                 hazard_o
);
    logic [REG_N-1:0] busy_q;
    logic [REG_N-1:0] busy_d;
    logic [REG_N-1:0] clr_mask_s;
    logic [REG_N-1:0] set_mask_s;
    logic [REG_N-1:0] busy_eff_s;

    // Apply clear before set so a same-index set/clear leaves the bit set
    always_comb begin
        clr_mask_s = '0;
        set_mask_s = '0;
        if (clr_en_i) clr_mask_s[clr_idx_i] = 1'b1;
        else          clr_mask_s = '0;
        if (set_en_i) set_mask_s[set_idx_i] = 1'b1;
        else          set_mask_s = '0;
        busy_eff_s = busy_q & ~clr_mask_s;
        busy_d     = busy_eff_s | set_mask_s;
        hazard_o   = (rd1_en_i && busy_eff_s[rd1_idx_i]) ||
                     (rd2_en_i && busy_eff_s[rd2_idx_i]);
    end

    // Busy-bit register, same edge as the rest of the pipeline
    always_ff @(negedge clk_i) begin
        if (rst_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: register file, hazard detection, branch wait FSM and the
// DE/EX pipeline latch. All state changes on the falling clock edge.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          I_CLOCK,
    input  logic          I_RESET,
    decode_stage_if.slave bus
);
    logic [OPC_W-1:0]     opcode_s;
    logic [REG_IDX_W-1:0] dest_s, src1_s, src2_s;
    logic [DATA_W-1:0]    imm_s, src1_val_s, src2_val_s;
    logic                 valid_s, is_branch_s, hazard_s, held_s, issue_s;
    de_state_e            state_q, state_d;
    logic [DATA_W-1:0]    rf_q [REG_N];

    logic                 lock_q;
    logic [PC_W-1:0]      pc_q;
    logic [OPC_W-1:0]     opc_q;
    logic [REG_IDX_W-1:0] dest_q;
    logic [DATA_W-1:0]    src1v_q, src2v_q, imm_q;

    assign opcode_s = bus.I_IR[OPC_MSB:OPC_LSB];
    assign dest_s   = bus.I_IR[DEST_MSB:DEST_LSB];
    assign src1_s   = bus.I_IR[SRC1_MSB:SRC1_LSB];
    assign src2_s   = bus.I_IR[SRC2_MSB:SRC2_LSB];
    assign imm_s    = bus.I_IR[IMM_MSB:IMM_LSB];

    reg_scoreboard u_sb (
        .clk_i     (I_CLOCK),
        .rst_i     (I_RESET),
        .set_en_i  (issue_s && writes_reg(opcode_s)),
        .set_idx_i (dest_s),
        .clr_en_i  (bus.I_WBEnable),
        .clr_idx_i (bus.I_WBRegIdx),
        .rd1_en_i  (reads_src1(opcode_s)),
        .rd1_idx_i (src1_s),
        .rd2_en_i  (reads_src2(opcode_s)),
        .rd2_idx_i (src2_s),
        .hazard_o  (hazard_s)
    );

    // Validity, hold/issue decision and write-before-read operand fetch
    always_comb begin
        valid_s     = bus.I_LOCK && !bus.I_FetchStall && (opcode_s != OP_NOP);
        is_branch_s = is_branch(opcode_s);
        held_s      = valid_s && (state_q == ST_IDLE) && hazard_s;
        issue_s     = valid_s && (state_q == ST_IDLE) && !hazard_s;
        if (bus.I_WBEnable && (bus.I_WBRegIdx == src1_s)) src1_val_s = bus.I_WBData;
        else                                              src1_val_s = rf_q[src1_s];
        if (bus.I_WBEnable && (bus.I_WBRegIdx == src2_s)) src2_val_s = bus.I_WBData;
        else                                              src2_val_s = rf_q[src2_s];
    end

    assign bus.O_DepStallSignal    = held_s;
    assign bus.O_BranchStallSignal = (state_q == ST_BR_WAIT) || (valid_s && is_branch_s);

    // Next-state logic: wait for resolution after a branch issues
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s && is_branch_s) state_d = ST_BR_WAIT;
                else                        state_d = ST_IDLE;
            end
            ST_BR_WAIT: begin
                if (bus.I_LOCK && bus.I_BranchResolved) state_d = ST_IDLE;
                else                                    state_d = ST_BR_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Register file; writeback proceeds regardless of pipeline lock
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
        end else if (bus.I_WBEnable) begin
            rf_q[bus.I_WBRegIdx] <= bus.I_WBData;
        end else begin
            rf_q <= rf_q;
        end
    end

    // DE/EX latch: issued instruction or a bubble
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            lock_q  <= 1'b0;
            pc_q    <= '0;
            opc_q   <= OP_NOP;
            dest_q  <= '0;
            src1v_q <= '0;
            src2v_q <= '0;
            imm_q   <= '0;
        end else begin
            lock_q <= bus.I_LOCK;
            if (issue_s) begin
                pc_q    <= bus.I_PC;
                opc_q   <= opcode_s;
                dest_q  <= dest_s;
                src1v_q <= src1_val_s;
                src2v_q <= src2_val_s;
                imm_q   <= imm_s;
            end else begin
                pc_q    <= '0;
                opc_q   <= OP_NOP;
                dest_q  <= '0;
                src1v_q <= '0;
                src2v_q <= '0;
                imm_q   <= '0;
            end
        end
    end

    assign bus.O_LOCK    = lock_q;
    assign bus.O_PC      = pc_q;
    assign bus.O_Opcode  = opc_q;
    assign bus.O_DestIdx = dest_q;
    assign bus.O_Src1Val = src1v_q;
    assign bus.O_Src2Val = src2v_q;
    assign bus.O_Imm     = imm_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the stage.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    decode_stage_if bus ();

    decode_stage dut (
        .I_CLOCK (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [15:0] m_rf [16];
    bit          m_busy [16];
    bit          m_brwait;
    bit          m_ok;
    logic        e_lock;
    logic [15:0] e_pc, e_s1, e_s2, e_imm;
    logic [7:0]  e_opc;
    logic [3:0]  e_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2);
        logic [31:0] w;
        w = {op, d, s1, 16'h0000};
        w[11:8] = s2;
        return w;
    endfunction

    // One clock: drive, check stalls, step model, check DE/EX latch
    task automatic cyc(input logic r, input logic lk, input logic fs, input logic [15:0] pc,
                       input logic [31:0] ir, input logic we, input logic [3:0] wi,
                       input logic [15:0] wd, input logic br);
        logic [7:0]  op;
        logic [3:0]  d, s1, s2;
        bit          valid, isbr, rd1, rd2, wr, held, issue;
        logic [15:0] v1, v2;
        rst = r;
        bus.I_LOCK = lk; bus.I_FetchStall = fs; bus.I_PC = pc; bus.I_IR = ir;
        bus.I_WBEnable = we; bus.I_WBRegIdx = wi; bus.I_WBData = wd;
        bus.I_BranchResolved = br;
        #1;
        op = ir[31:24]; d = ir[23:20]; s1 = ir[19:16]; s2 = ir[11:8];
        valid = lk && !fs && (op != 8'hFF);
        isbr  = op inside {OP_BRZ, OP_BRN, OP_JMP};
        rd1   = op inside {OP_ADD, OP_SUB, OP_AND, OP_STW, OP_BRZ, OP_BRN};
        rd2   = op inside {OP_ADD, OP_SUB, OP_AND, OP_STW};
        wr    = op inside {OP_ADD, OP_SUB, OP_AND, OP_LDI};
        held  = valid && !m_brwait &&
                ((rd1 && m_busy[s1] && !(we && wi == s1)) ||
                 (rd2 && m_busy[s2] && !(we && wi == s2)));
        issue = valid && !m_brwait && !held;
        v1 = (we && wi == s1) ? wd : m_rf[s1];
        v2 = (we && wi == s2) ? wd : m_rf[s2];
        if (m_ok) begin
            chk("dep_stall", {31'd0, bus.O_DepStallSignal}, {31'd0, held});
            chk("br_stall", {31'd0, bus.O_BranchStallSignal}, {31'd0, m_brwait || (valid && isbr)});
        end
        if (r) begin
            for (int i = 0; i < 16; i++) begin m_rf[i] = 16'h0; m_busy[i] = 1'b0; end
            m_brwait = 1'b0; m_ok = 1'b1;
            e_lock = 1'b0; e_pc = 16'h0; e_opc = 8'hFF; e_dest = 4'h0;
            e_s1 = 16'h0; e_s2 = 16'h0; e_imm = 16'h0;
        end else begin
            if (we) begin m_rf[wi] = wd; m_busy[wi] = 1'b0; end
            if (issue && wr) m_busy[d] = 1'b1;
            if (lk && !m_brwait && issue && isbr) m_brwait = 1'b1;
            else if (lk && m_brwait && br) m_brwait = 1'b0;
            e_lock = lk;
            if (issue) begin
                e_pc = pc; e_opc = op; e_dest = d; e_s1 = v1; e_s2 = v2; e_imm = ir[15:0];
            end else begin
                e_pc = 16'h0; e_opc = 8'hFF; e_dest = 4'h0; e_s1 = 16'h0; e_s2 = 16'h0; e_imm = 16'h0;
            end
        end
        @(negedge clk);
        #2;
        chk("o_lock", {31'd0, bus.O_LOCK}, {31'd0, e_lock});
        chk("o_opcode", {24'd0, bus.O_Opcode}, {24'd0, e_opc});
        chk("o_dest", {28'd0, bus.O_DestIdx}, {28'd0, e_dest});
        if (e_opc != 8'hFF) begin
            chk("o_pc", {16'd0, bus.O_PC}, {16'd0, e_pc});
            chk("o_src1", {16'd0, bus.O_Src1Val}, {16'd0, e_s1});
            chk("o_src2", {16'd0, bus.O_Src2Val}, {16'd0, e_s2});
            chk("o_imm", {16'd0, bus.O_Imm}, {16'd0, e_imm});
        end
    endtask

    // Shorthand: run with lock=1, no fetch stall, no resolve
    task automatic run(input logic [15:0] pc, input logic [31:0] ir, input logic we,
                       input logic [3:0] wi, input logic [15:0] wd);
        cyc(1'b0, 1'b1, 1'b0, pc, ir, we, wi, wd, 1'b0);
    endtask

    initial begin
        logic [31:0] nop_w;
        logic [7:0]  ops [9];
        checks = 0; failures = 0; m_ok = 1'b0;
        nop_w = {8'hFF, 24'h000000};
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_LDI, OP_STW, OP_BRZ, OP_BRN, OP_JMP, OP_NOP};

        // Reset and reset-value checks
        cyc(1'b1, 1'b0, 1'b1, 16'h0, nop_w, 1'b0, 4'h0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0, nop_w, 1'b0, 4'h0, 16'h0, 1'b0);
        chk("reset_opcode", {24'd0, bus.O_Opcode}, 32'h0000_00FF);

        // ADD r1,r2,r3 then SUB r4,r1,r2 held until WB r1=5
        run(16'h0004, mk(OP_ADD, 4'd1, 4'd2, 4'd3), 1'b0, 4'd0, 16'h0);
        chk("add_dest", {28'd0, bus.O_DestIdx}, 32'd1);
        run(16'h0008, mk(OP_SUB, 4'd4, 4'd1, 4'd2), 1'b0, 4'd0, 16'h0);
        run(16'h0008, mk(OP_SUB, 4'd4, 4'd1, 4'd2), 1'b0, 4'd0, 16'h0);
        run(16'h0008, mk(OP_SUB, 4'd4, 4'd1, 4'd2), 1'b1, 4'd1, 16'h0005);
        chk("sub_src1", {16'd0, bus.O_Src1Val}, 32'h0000_0005);

        // Same-cycle ADD r3 issue and WB r3 keeps r3 busy
        run(16'h000C, mk(OP_ADD, 4'd3, 4'd0, 4'd0), 1'b1, 4'd3, 16'h0033);
        run(16'h0010, mk(OP_AND, 4'd5, 4'd3, 4'd3), 1'b0, 4'd0, 16'h0);
        run(16'h0010, mk(OP_AND, 4'd5, 4'd3, 4'd3), 1'b1, 4'd3, 16'h0077);
        run(16'h0014, mk(OP_ADD, 4'd6, 4'd5, 4'd0), 1'b1, 4'd5, 16'h0042);
        run(16'h0014, mk(OP_ADD, 4'd6, 4'd5, 4'd0), 1'b1, 4'd4, 16'h0001);

        // BRZ at 0x0010, BR_WAIT, resolve cycle drops its instruction
        run(16'h0010, mk(OP_BRZ, 4'd0, 4'd0, 4'd0), 1'b1, 4'd6, 16'h0002);
        run(16'h0014, mk(OP_ADD, 4'd7, 4'd0, 4'd0), 1'b0, 4'd0, 16'h0);
        run(16'h0018, mk(OP_LDI, 4'd7, 4'd0, 4'd0), 1'b0, 4'd0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0040, mk(OP_ADD, 4'd8, 4'd0, 4'd0), 1'b0, 4'd0, 16'h0, 1'b1);
        run(16'h0044, mk(OP_ADD, 4'd9, 4'd1, 4'd0), 1'b0, 4'd0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0048, nop_w, 1'b0, 4'd0, 16'h0, 1'b1);

        // BRZ reading busy r2: both stalls, then issue on WB r2
        run(16'h0050, {OP_LDI, 4'd2, 4'd0, 16'h1234}, 1'b1, 4'd9, 16'h0009);
        run(16'h0054, mk(OP_BRZ, 4'd0, 4'd2, 4'd0), 1'b0, 4'd0, 16'h0);
        run(16'h0054, mk(OP_BRZ, 4'd0, 4'd2, 4'd0), 1'b1, 4'd2, 16'h0000);
        run(16'h0058, mk(OP_ADD, 4'd1, 4'd0, 4'd0), 1'b0, 4'd0, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 16'h005C, nop_w, 1'b0, 4'd0, 16'h0, 1'b1);

        // Reset during BR_WAIT with r5 busy
        run(16'h0060, {OP_LDI, 4'd5, 4'd0, 16'h00AA}, 1'b0, 4'd0, 16'h0);
        run(16'h0064, mk(OP_JMP, 4'd0, 4'd0, 4'd0), 1'b0, 4'd0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0068, mk(OP_ADD, 4'd1, 4'd5, 4'd5), 1'b1, 4'd7, 16'hBEEF, 1'b0);
        run(16'h006C, mk(OP_ADD, 4'd1, 4'd5, 4'd7), 1'b0, 4'd0, 16'h0);
        chk("post_reset_src2", {16'd0, bus.O_Src2Val}, 32'h0);

        // Lock low: bubbles, writeback still lands
        cyc(1'b0, 1'b0, 1'b0, 16'h0070, mk(OP_ADD, 4'd2, 4'd3, 4'd0), 1'b1, 4'd3, 16'h5A5A, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0070, mk(OP_BRN, 4'd0, 4'd3, 4'd0), 1'b0, 4'd0, 16'h0, 1'b0);
        run(16'h0074, mk(OP_STW, 4'd0, 4'd3, 4'd1), 1'b0, 4'd0, 16'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [7:0] op;
            op = ops[$urandom_range(8, 0)];
            cyc(($urandom_range(99, 0) == 0),
                ($urandom_range(9, 0) != 0),
                ($urandom_range(7, 0) == 0),
                16'($urandom),
                {op, 4'($urandom_range(7, 0)), 4'($urandom_range(7, 0)),
                 4'($urandom), 4'($urandom_range(7, 0)), 8'($urandom)},
                ($urandom_range(2, 0) == 0),
                4'($urandom_range(7, 0)),
                16'($urandom),
                ($urandom_range(3, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
